// File: rtl/select_seq_pkg.sv
// rtl/select_seq_pkg.sv - shared constants for the select sequencer
package select_seq_pkg;

    localparam int               SEL_W       = 2;
    localparam logic [SEL_W-1:0] SEL_MAX     = 2'd3;
    // Board buttons pull the line low when pressed
    localparam logic             BTN_PRESSED = 1'b0;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-FF synchroniser, debouncer and single-cycle press pulse for one button
module btn_debounce
    import select_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic press
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic             stable;
    logic [CNT_W-1:0] cnt;

    // Two-stage synchroniser; resets to the released level so a held button looks like a fresh press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= ~BTN_PRESSED;
            sync_2 <= ~BTN_PRESSED;
        end else begin
            sync_1 <= btn_n;
            sync_2 <= sync_1;
        end
    end

    // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples; any agreeing sample restarts the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= ~BTN_PRESSED;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync_2 != stable) begin
                if (cnt == CNT_LAST) begin
                    stable <= sync_2;
                    cnt    <= '0;
                    press  <= (sync_2 == BTN_PRESSED);
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/select_sequencer.sv
// rtl/select_sequencer.sv - button-driven en/a1/a0 select generator; SELECT_SEQUENCER_AUTO_STEP_EN adds timed auto-stepping
module select_sequencer
    import select_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int AUTO_PERIOD     = 12000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_step_n,
    input  logic btn_en_n,
    output logic en,
    output logic a1,
    output logic a0,
    output logic sel_changed
);

    if (DEBOUNCE_CYCLES < 2 || AUTO_PERIOD < 2) begin : g_param_check
        $error("select_sequencer: DEBOUNCE_CYCLES and AUTO_PERIOD must both be at least 2");
    end

    logic             step_press;
    logic             en_press;
    logic             do_step;
    logic [SEL_W-1:0] sel;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (btn_step_n),
        .press (step_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_en_db (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (btn_en_n),
        .press (en_press)
    );

`ifdef SELECT_SEQUENCER_AUTO_STEP_EN
    localparam int                AUTO_W    = $clog2(AUTO_PERIOD);
    localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_PERIOD - 1);

    logic [AUTO_W-1:0] auto_cnt;
    logic              auto_tick;

    assign auto_tick = en && (auto_cnt == AUTO_LAST);

    // Free-running period counter while enabled; a manual step restarts the period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            auto_cnt <= '0;
        end else if (!en || step_press || auto_tick) begin
            auto_cnt <= '0;
        end else begin
            auto_cnt <= auto_cnt + AUTO_W'(1);
        end
    end

    // A tick coinciding with a manual press still advances by one
    assign do_step = step_press | auto_tick;
`else
    assign do_step = step_press;
`endif

    // Select, enable and change-flag registers that drive the encoder directly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en          <= 1'b0;
            sel         <= '0;
            sel_changed <= 1'b0;
        end else begin
            sel_changed <= do_step;
            if (do_step) begin
                sel <= (sel == SEL_MAX) ? '0 : sel + SEL_W'(1);
            end
            if (en_press) begin
                en <= ~en;
            end
        end
    end

    assign a1 = sel[1];
    assign a0 = sel[0];

endmodule
